// File: rtl/param_mod_counter.sv
// ---------------------------------------------------------------------------
// param_mod_counter
//
// Modulo-N up/down counter for multicycle sequencing (step counters, stall
// timers, tick dividers). The count runs over 0..MODULUS-1 and either wraps
// or saturates at the range ends. It has synchronous clear and load, a
// combinational terminal-count output for ripple-enable cascades, and a
// registered one-cycle wrap pulse.
//
// Parameters
//   WIDTH       counter width in bits (1..32)
//   MODULUS     count range 0..MODULUS-1 (2..2^WIDTH)
//   SATURATE    0 = wrap at the range ends, 1 = hold at the range ends
//   RESET_VALUE count after reset (< MODULUS)
//
// Ports
//   clock       sole clock, rising edge
//   reset       synchronous, active-low reset
//   enable      step request for this cycle
//   up          1 = increment, 0 = decrement
//   clear       synchronous clear to 0 (highest priority after reset)
//   load        synchronous load of load_value (clamped to MODULUS-1)
//   load_value  value to load
//   count       current count (registered)
//   tc          enable & count is at the range end for the current direction
//   wrapped     one-cycle pulse, coincident with the count produced by a wrap
//   at_limit    count is at the range end for the current direction
// ---------------------------------------------------------------------------
module param_mod_counter #(
  parameter int     WIDTH       = 6,
  parameter longint MODULUS     = 64,
  parameter bit     SATURATE    = 1'b0,
  parameter longint RESET_VALUE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped,
  output logic             at_limit
);

  // MODULUS is held in 64 bits so that MODULUS == 2^32 is representable.
  // When MODULUS == 2^WIDTH, MAX_VAL is all ones and every comparison below
  // turns into natural rollover.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrapped_reg;
  logic             wrapped_next;
  logic             at_top;
  logic             at_bottom;
  logic             at_end;

  assign at_top    = (count_reg == MAX_VAL);
  assign at_bottom = (count_reg == '0);
  // The range end depends on the current direction. It uses the live `up`
  // input, so a direction change is seen in the same cycle.
  assign at_end    = up ? at_top : at_bottom;

  always_comb begin
    count_next   = count_reg;
    wrapped_next = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else if (enable) begin
      if (!at_end) begin
        count_next = up ? count_reg + 1'b1 : count_reg - 1'b1;
      end else if (!SATURATE) begin
        count_next   = up ? '0 : MAX_VAL;
        wrapped_next = 1'b1;
      end
      // In saturate mode the count stays at the range end and no wrap
      // pulse is produced.
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_reg   <= RST_VAL;
      wrapped_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign count    = count_reg;
  assign wrapped  = wrapped_reg;
  assign at_limit = at_end;
  // The terminal count does not depend on SATURATE, clear or load. A cascade
  // therefore sees the same enable that a ripple chain would.
  assign tc       = enable & at_end;

endmodule
